// File: rtl/game_dumper.sv
// ---------------------------------------------------------------------------
// game_dumper
//
// Streams a cartridge image in iNES layout: a 16-byte header built from the
// parameters captured at start, then every PRG byte (cartridge address
// 0x000000 upward), then every CHR byte (cartridge address 0x200000 upward,
// skipped when chr_pages is 0). Each data byte is fetched with a single
// outstanding memory read and forwarded through a valid/ready byte port.
//
// Ports
//   clk, reset            clock (rising edge) and synchronous active-high reset
//   start                 one-cycle pulse that begins a dump (ignored while busy)
//   prg_pages             PRG size in 16 KB units (legal range 1..128)
//   chr_pages             CHR size in 8 KB units, 0 = no CHR section
//   mapper                mapper number for header bytes 6/7
//   mirroring             header byte 6 bit 0
//   four_screen           header byte 6 bit 3
//   mem_addr/mem_read     read request, held stable until mem_ack
//   mem_ack/mem_data      read completion, data valid with mem_ack
//   out_data/out_valid    output byte, held stable until out_ready
//   out_ready             sink acceptance
//   busy                  dump in progress
//   done/error            end-of-dump flags (error = rejected PRG size)
//
// Configuration
//   GAME_DUMPER_NES20_EN  when defined, header byte 7 carries the NES 2.0
//                         identifier (bits [3:2] = 2'b10); otherwise the
//                         header is plain iNES 1.0.
// ---------------------------------------------------------------------------
module game_dumper (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  prg_pages,
  input  logic [7:0]  chr_pages,
  input  logic [7:0]  mapper,
  input  logic        mirroring,
  input  logic        four_screen,
  output logic [21:0] mem_addr,
  output logic        mem_read,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_REQ,
    S_SEND,
    S_FIN
  } state_t;

`ifdef GAME_DUMPER_NES20_EN
  localparam logic [3:0] HDR7_LOW = 4'b1000;
`else
  localparam logic [3:0] HDR7_LOW = 4'b0000;
`endif

  localparam logic [21:0] CHR_BASE = 22'h200000;

  // Header byte generator; the parameters are the latched copies so the
  // header stays consistent even if the inputs change mid-dump.
  function automatic logic [7:0] header_byte(
    input logic [3:0] idx,
    input logic [7:0] prg,
    input logic [7:0] chr,
    input logic [7:0] map,
    input logic       mir,
    input logic       fs
  );
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h4E;
      4'd1:    b = 8'h45;
      4'd2:    b = 8'h53;
      4'd3:    b = 8'h1A;
      4'd4:    b = prg;
      4'd5:    b = chr;
      4'd6:    b = {map[3:0], fs, 2'b00, mir};
      4'd7:    b = {map[7:4], HDR7_LOW};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // State and datapath registers
  state_t      r_state;
  logic [3:0]  r_hdr_idx;
  logic [7:0]  r_prg_pages;
  logic [7:0]  r_chr_pages;
  logic [7:0]  r_mapper;
  logic        r_mirroring;
  logic        r_four_screen;
  logic        r_reject;
  logic        r_section_chr;
  logic [21:0] r_remaining;
  logic [21:0] r_mem_addr;
  logic        r_mem_read;
  logic [7:0]  r_out_data;
  logic        r_out_valid;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  // Next-state values
  state_t      w_state_next;
  logic [3:0]  w_hdr_idx_next;
  logic [7:0]  w_prg_pages_next;
  logic [7:0]  w_chr_pages_next;
  logic [7:0]  w_mapper_next;
  logic        w_mirroring_next;
  logic        w_four_screen_next;
  logic        w_reject_next;
  logic        w_section_chr_next;
  logic [21:0] w_remaining_next;
  logic [21:0] w_mem_addr_next;
  logic        w_mem_read_next;
  logic [7:0]  w_out_data_next;
  logic        w_out_valid_next;
  logic        w_busy_next;
  logic        w_done_next;
  logic        w_error_next;

  // Helpers
  logic        w_out_fire;
  logic        w_mem_fire;
  logic [3:0]  w_hdr_idx_inc;
  logic [7:0]  w_hdr_following;
  logic [21:0] w_rem_dec;
  logic        w_bad_size;

  // Handshakes only count while this side is actually asserting, so a stray
  // out_ready or mem_ack is harmless.
  assign w_out_fire      = r_out_valid & out_ready;
  assign w_mem_fire      = r_mem_read & mem_ack;
  assign w_hdr_idx_inc   = r_hdr_idx + 4'd1;
  assign w_rem_dec       = r_remaining - 22'd1;
  assign w_bad_size      = (prg_pages == 8'd0) || (prg_pages > 8'd128);
  assign w_hdr_following = header_byte(w_hdr_idx_inc, r_prg_pages, r_chr_pages,
                                       r_mapper, r_mirroring, r_four_screen);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_hdr_idx     <= 4'd0;
      r_prg_pages   <= 8'd0;
      r_chr_pages   <= 8'd0;
      r_mapper      <= 8'd0;
      r_mirroring   <= 1'b0;
      r_four_screen <= 1'b0;
      r_reject      <= 1'b0;
      r_section_chr <= 1'b0;
      r_remaining   <= 22'd0;
      r_mem_addr    <= 22'd0;
      r_mem_read    <= 1'b0;
      r_out_data    <= 8'd0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_hdr_idx     <= w_hdr_idx_next;
      r_prg_pages   <= w_prg_pages_next;
      r_chr_pages   <= w_chr_pages_next;
      r_mapper      <= w_mapper_next;
      r_mirroring   <= w_mirroring_next;
      r_four_screen <= w_four_screen_next;
      r_reject      <= w_reject_next;
      r_section_chr <= w_section_chr_next;
      r_remaining   <= w_remaining_next;
      r_mem_addr    <= w_mem_addr_next;
      r_mem_read    <= w_mem_read_next;
      r_out_data    <= w_out_data_next;
      r_out_valid   <= w_out_valid_next;
      r_busy        <= w_busy_next;
      r_done        <= w_done_next;
      r_error       <= w_error_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_hdr_idx_next     = r_hdr_idx;
    w_prg_pages_next   = r_prg_pages;
    w_chr_pages_next   = r_chr_pages;
    w_mapper_next      = r_mapper;
    w_mirroring_next   = r_mirroring;
    w_four_screen_next = r_four_screen;
    w_reject_next      = r_reject;
    w_section_chr_next = r_section_chr;
    w_remaining_next   = r_remaining;
    w_mem_addr_next    = r_mem_addr;
    w_mem_read_next    = r_mem_read;
    w_out_data_next    = r_out_data;
    w_out_valid_next   = r_out_valid;
    w_busy_next        = r_busy;
    w_done_next        = r_done;
    w_error_next       = r_error;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_prg_pages_next   = prg_pages;
          w_chr_pages_next   = chr_pages;
          w_mapper_next      = mapper;
          w_mirroring_next   = mirroring;
          w_four_screen_next = four_screen;
          w_done_next        = 1'b0;
          w_error_next       = 1'b0;
          w_busy_next        = 1'b1;
          if (w_bad_size) begin
            // Rejected sizes finish without touching memory or the sink.
            w_reject_next = 1'b1;
            w_state_next  = S_FIN;
          end else begin
            // Header byte 0 is a constant, so it can be presented in the
            // very next cycle without waiting for the latched parameters.
            w_reject_next    = 1'b0;
            w_hdr_idx_next   = 4'd0;
            w_out_data_next  = 8'h4E;
            w_out_valid_next = 1'b1;
            w_state_next     = S_HDR;
          end
        end
      end

      S_HDR: begin
        if (w_out_fire) begin
          if (r_hdr_idx == 4'd15) begin
            w_out_valid_next   = 1'b0;
            w_section_chr_next = 1'b0;
            w_mem_addr_next    = 22'd0;
            w_remaining_next   = {r_prg_pages, 14'b0};
            w_mem_read_next    = 1'b1;
            w_state_next       = S_REQ;
          end else begin
            w_hdr_idx_next  = w_hdr_idx_inc;
            w_out_data_next = w_hdr_following;
          end
        end
      end

      S_REQ: begin
        if (w_mem_fire) begin
          w_out_data_next  = mem_data;
          w_mem_read_next  = 1'b0;
          w_out_valid_next = 1'b1;
          w_state_next     = S_SEND;
        end
      end

      S_SEND: begin
        if (w_out_fire) begin
          w_out_valid_next = 1'b0;
          w_mem_addr_next  = r_mem_addr + 22'd1;
          w_remaining_next = w_rem_dec;
          if (w_rem_dec != 22'd0) begin
            w_mem_read_next = 1'b1;
            w_state_next    = S_REQ;
          end else if (!r_section_chr && (r_chr_pages != 8'd0)) begin
            // PRG finished and a CHR ROM exists: restart at the CHR window.
            w_section_chr_next = 1'b1;
            w_mem_addr_next    = CHR_BASE;
            w_remaining_next   = {1'b0, r_chr_pages, 13'b0};
            w_mem_read_next    = 1'b1;
            w_state_next       = S_REQ;
          end else begin
            w_state_next = S_FIN;
          end
        end
      end

      S_FIN: begin
        // start is not examined here, so a pulse coinciding with this
        // cycle is dropped.
        w_done_next  = 1'b1;
        w_error_next = r_reject;
        w_busy_next  = 1'b0;
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign mem_addr  = r_mem_addr;
  assign mem_read  = r_mem_read;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: doc/game_dumper.md
GAME_DUMPER -- requirements
Module: game_dumper

Interface
REQ-001: clk  in  1  clock; all logic on rising edge.
REQ-002: reset  in  1  synchronous, active-high.
REQ-003: start  in  1  one-cycle pulse; begins a dump; ignored while busy=1.
REQ-004: prg_pages  in  8  PRG size in 16 KB units; latched on accepted start.
REQ-005: chr_pages  in  8  CHR size in 8 KB units, 0 = CHR RAM (no CHR section); latched on start.
REQ-006: mapper  in  8  mapper number; latched on start.
REQ-007: mirroring  in  1  header byte 6 bit 0; latched on start.
REQ-008: four_screen  in  1  header byte 6 bit 3; latched on start.
REQ-009: mem_addr  out  22  byte address into cartridge memory.
REQ-010: mem_read  out  1  read request; held with mem_addr stable until mem_ack.
REQ-011: mem_ack  in  1  read complete; mem_data valid in the same cycle.
REQ-012: mem_data  in  8  read data.
REQ-013: out_data  out  8  output byte stream.
REQ-014: out_valid  out  1  out_data valid; held with out_data stable until out_ready.
REQ-015: out_ready  in  1  sink accepts a byte when out_valid and out_ready are both 1.
REQ-016: busy  out  1  dump in progress.
REQ-017: done  out  1  level; set when dump ends, cleared by the next accepted start or by reset.
REQ-018: error  out  1  level; set with done when the dump is rejected.

Function
REQ-019: States: IDLE, HDR, REQ, SEND, FIN.
REQ-020: IDLE + start: latch inputs, clear done and error, set busy. If prg_pages==0 or prg_pages>128, go to FIN with error=1 and emit no bytes; otherwise go to HDR with header index 0.
REQ-021: HDR: emit 16 header bytes in order. Bytes 0-3 are 4E,45,53,1A. Byte 4 is prg_pages. Byte 5 is chr_pages. Byte 6 is {mapper[3:0],four_screen,0,0,mirroring}. Byte 7 is {mapper[7:4],4'b0000}. Bytes 8-15 are 00.
REQ-022: out_valid rises the cycle after start is accepted; each byte advances only on its handshake; back-to-back bytes are allowed when out_ready is held at 1.
REQ-023: After header byte 15 handshakes: section=PRG, mem_addr=0, remaining={prg_pages,14'b0}; go to REQ.
REQ-024: REQ: mem_read=1 until mem_ack. On mem_ack: capture mem_data into out_data, drop mem_read the next cycle, go to SEND.
REQ-025: SEND: out_valid=1 until the handshake. On the handshake: increment mem_addr, decrement remaining. If remaining is still nonzero, go to REQ; otherwise end the section.
REQ-026: End of PRG section: if chr_pages!=0, set section=CHR, mem_addr=22'h200000, remaining={1'b0,chr_pages,13'b0}, and go to REQ. Otherwise go to FIN.
REQ-027: End of CHR section: go to FIN.
REQ-028: FIN: done=1, busy=0, go to IDLE in the same cycle.
REQ-029: Byte counter is 22 bits; all arithmetic is modulo 2^22. The maximum legal PRG size (128 pages = 2 MB) ends exactly at 22'h1FFFFF.
REQ-030: mem_read and out_valid are never 1 in the same cycle; at most one memory read is outstanding.
REQ-031: A start arriving in the same cycle as the FIN transition is ignored.
REQ-032: mem_ack arriving while mem_read=0 is ignored.
REQ-033: out_ready while out_valid=0 has no effect.
REQ-034: Total bytes emitted = 16 + 16384*prg_pages + 8192*chr_pages.

Reset
REQ-035: reset forces state IDLE and sets mem_addr=0, mem_read=0, out_valid=0, out_data=0, busy=0, done=0, error=0.
REQ-036: reset overrides every other input in the same cycle, including start and an in-flight handshake.
REQ-037: Reset mid-dump abandons the dump silently; no byte is emitted after reset is deasserted until a new start.

Configuration
REQ-038: Macro GAME_DUMPER_NES20_EN.
- Defined: header byte 7 is {mapper[7:4],2'b10,2'b00} (NES 2.0 identifier); bytes 8-15 remain 00.
- Undefined: byte 7 bits [3:2]=2'b00 (plain iNES 1.0).
- No other behaviour differs.

Verification
REQ-039: prg=1, chr=1, mapper=0, mirroring=1, sink always ready, mem_ack 2 cycles after each request -> 16+16384+8192 bytes. Header is 4E 45 53 1A 01 01 01 00 then 8x00. First PRG read at 0x000000; first CHR read at 0x200000; done=1, error=0.
REQ-040: prg=2, chr=0, mapper=0x45, four_screen=1 -> byte6=0x58, byte7=0x40 (0x48 with GAME_DUMPER_NES20_EN). Emits 32768 data bytes. Last mem_addr read is 0x007FFF; no address ≥0x200000 is requested.
REQ-041: prg=0 -> done=1, error=1 two cycles after start; out_valid and mem_read never asserted. Repeat with prg=129 -> same response.
REQ-042: Random out_ready stalls (50%) and random mem_ack delay 0-5 cycles -> byte sequence identical to the unstalled run; out_data is stable while out_valid=1 and out_ready=0.
REQ-043: reset asserted during PRG byte 100 -> next cycle all outputs are 0. A new start with prg=1, chr=0 -> a complete clean stream beginning with 4E.
REQ-044: start pulsed while busy -> ignored; the stream is unchanged and latched parameters are unchanged.
